uart_event_framer: RTL and testbench

Game-event packetiser between the whack-a-mole game logic and `uart_tx`. Captures single-cycle event pulses (mole moved, mole hit, game over) into a small FIFO. Serialises each event as a 3-byte framed packet (type, payload, checksum), driving the transmitter's `tx_start`/`tx_data`/`tx_busy` handshake one byte at a time. It replaces the ad-hoc mole-position sender in the top level and gives the PC a checksummed event stream.

---
 rtl/uart_event_framer.sv | 183 ++++++++++++++++++
 tb/tb_uart_event_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_event_framer.sv
// Event packetiser: queues mole/hit/game-over pulses and serialises each one as a
// 3-byte packet (type, payload, checksum) over the uart_tx start/busy handshake.
`timescale 1ns/1ps
module uart_event_framer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_mole_event,
    input  logic [4:0]                    i_mole_pos,
    input  logic                          i_hit_event,
    input  logic                          i_over_event,
    input  logic [5:0]                    i_score,
    input  logic                          i_tx_busy,
    output logic                          o_tx_start,
    output logic [7:0]                    o_tx_data,
    output logic                          o_framer_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic [7:0]                    o_dropped_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [1:0]    TYPE_M   = 2'd0;
    localparam logic [1:0]    TYPE_H   = 2'd1;
    localparam logic [1:0]    TYPE_G   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    function automatic logic [7:0] type_ascii(input logic [1:0] t);
        case (t)
            TYPE_H:  return 8'h48;
            TYPE_G:  return 8'h47;
            default: return 8'h4D;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t        r_state, w_state_next;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_dropped;
    logic [1:0]    r_byte_idx, w_idx_next;
    logic [TW-1:0] r_tmo, w_tmo_next;
    logic [7:0]    r_tx_data, r_pkt1, r_pkt2;
    logic [7:0]    w_push_data, w_head, w_load_byte;
    logic [1:0]    w_n_evt, w_losers, w_drop_inc;
    logic          w_push, w_accept, w_pop, w_load, w_tx_start, w_byte_done;

    // Event arbitration: one push per cycle, every other simultaneous pulse is a drop
    assign w_n_evt    = {1'b0, i_over_event} + {1'b0, i_hit_event} + {1'b0, i_mole_event};
    assign w_push     = i_over_event | i_hit_event | i_mole_event;
    assign w_losers   = w_push ? (w_n_evt - 2'd1) : 2'd0;
    assign w_accept   = w_push & ((r_count != CNT_FULL) | w_pop);
    assign w_drop_inc = w_losers + {1'b0, w_push & ~w_accept};
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_push_data = {TYPE_M, 1'b0, i_mole_pos};
        if (i_over_event)
            w_push_data = {TYPE_G, i_score};
        else if (i_hit_event)
            w_push_data = {TYPE_H, i_score};
    end

    always_ff @(posedge i_clock) begin
        if (w_accept)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_dropped <= sat_add(r_dropped, w_drop_inc);
        end
    end

    // Packet FSM
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_tmo      <= '0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_idx_next;
            r_tmo      <= w_tmo_next;
            if (w_load)
                r_tx_data <= w_load_byte;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_pop) begin
            r_pkt1 <= {2'b00, w_head[5:0]};
            r_pkt2 <= type_ascii(w_head[7:6]) ^ {2'b00, w_head[5:0]};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_byte_idx;
        w_tmo_next   = r_tmo;
        w_tx_start   = 1'b0;
        w_load       = 1'b0;
        w_load_byte  = 8'h00;
        w_pop        = 1'b0;
        w_byte_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_idx_next   = 2'd0;
                    w_load       = 1'b1;
                    w_load_byte  = type_ascii(w_head[7:6]);
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (!i_tx_busy) begin
                    w_tx_start   = 1'b1;
                    w_tmo_next   = '0;
                    w_state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // A transmitter that never acknowledges must not stall the stream
                if (i_tx_busy)
                    w_state_next = S_WAIT_DONE;
                else if (r_tmo == TMO_LAST)
                    w_byte_done = 1'b1;
                else
                    w_tmo_next = r_tmo + TMO_ONE;
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy)
                    w_byte_done = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_byte_done) begin
            if (r_byte_idx == 2'd2) begin
                w_state_next = S_IDLE;
            end else begin
                w_idx_next   = r_byte_idx + 2'd1;
                w_load       = 1'b1;
                w_load_byte  = (r_byte_idx == 2'd0) ? r_pkt1 : r_pkt2;
                w_state_next = S_SEND;
            end
        end
    end

    assign o_tx_start      = w_tx_start & i_reset;
    assign o_tx_data       = r_tx_data;
    assign o_framer_busy   = (r_count != '0) | (r_state != S_IDLE);
    assign o_fifo_count    = r_count;
    assign o_dropped_count = r_dropped;
endmodule

// File: tb/tb_uart_event_framer.sv
// Directed bench for uart_event_framer with a small uart_tx busy model.
`timescale 1ns/1ps
module tb_uart_event_framer;
    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 4;
    localparam int BUSY_LEN    = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mole_event = 1'b0, hit_event = 1'b0, over_event = 1'b0;
    logic [4:0] mole_pos = 5'd0;
    logic [5:0] score = 6'd0;
    logic       tx_busy, tx_start, framer_busy;
    logic [7:0] tx_data, dropped_count;
    logic [2:0] fifo_count;

    logic       model_en = 1'b0, busy_force = 1'b0, start_seen = 1'b0;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         vec = 0, err = 0;
    logic [7:0] bytes_q[$];
    int         starts_q[$];

    uart_event_framer #(.FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .i_clock(clock), .i_reset(reset), .i_mole_event(mole_event), .i_mole_pos(mole_pos),
        .i_hit_event(hit_event), .i_over_event(over_event), .i_score(score),
        .i_tx_busy(tx_busy), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_framer_busy(framer_busy), .o_fifo_count(fifo_count), .o_dropped_count(dropped_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // uart_tx stand-in: busy for BUSY_LEN cycles after each accepted start
    assign tx_busy = busy_force | (busy_cnt != 0);
    always @(posedge clock) begin
        if (model_en && start_seen) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
    end
    always @(negedge clock) begin
        start_seen <= tx_start;
        if (tx_start) begin
            bytes_q.push_back(tx_data);
            starts_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_en = 1'b1;
        busy_force = 1'b0;
        repeat (12) step();
        bytes_q.delete();
        starts_q.delete();
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc, output bit timed_out);
        timed_out = 1'b1;
        idle_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!framer_busy && !tx_busy) begin
                timed_out = 1'b0;
                idle_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (tx_start !== 1'b0) begin err++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        vec++; if (tx_data !== 8'h00) begin err++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        vec++; if (framer_busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b want 0", framer_busy); end
        vec++; if (fifo_count !== 3'd0) begin err++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        vec++; if (dropped_count !== 8'd0) begin err++; $display("FAIL rst_dropped: got %0d want 0", dropped_count); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_mole();
        int k, idle; bit to;
        do_reset(); reset = 1'b1; step();
        k = cyc;
        mole_pos = 5'b00100; mole_event = 1'b1;
        step();
        mole_event = 1'b0;
        wait_idle(300, idle, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL single_timeout: got %b want 0", to); end
        vec++; if (bytes_q.size() != 3) begin err++; $display("FAIL single_nstart: got %0d want 3", bytes_q.size()); end
        vec++; if (bytes_q[0] !== 8'h4D) begin err++; $display("FAIL single_b0: got %h want 4d", bytes_q[0]); end
        vec++; if (bytes_q[1] !== 8'h04) begin err++; $display("FAIL single_b1: got %h want 04", bytes_q[1]); end
        vec++; if (bytes_q[2] !== 8'h49) begin err++; $display("FAIL single_b2: got %h want 49", bytes_q[2]); end
        vec++; if (starts_q[0] != k + 2) begin err++; $display("FAIL single_lat: got %0d want %0d", starts_q[0], k + 2); end
        vec++; if (starts_q[1] != k + 14) begin err++; $display("FAIL single_t1: got %0d want %0d", starts_q[1], k + 14); end
        vec++; if (starts_q[2] != k + 26) begin err++; $display("FAIL single_t2: got %0d want %0d", starts_q[2], k + 26); end
        vec++; if (idle != k + 38) begin err++; $display("FAIL single_busy_fall: got %0d want %0d", idle, k + 38); end
        vec++; if (tx_data !== 8'h49) begin err++; $display("FAIL single_hold: got %h want 49", tx_data); end
    endtask

    task automatic test_simultaneous();
        int idle; bit to;
        do_reset(); reset = 1'b1; step();
        score = 6'd17; over_event = 1'b1; hit_event = 1'b1; mole_event = 1'b1; mole_pos = 5'b00001;
        step();
        over_event = 1'b0; hit_event = 1'b0; mole_event = 1'b0;
        wait_idle(300, idle, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL simul_timeout: got %b want 0", to); end
        vec++; if (bytes_q.size() != 3) begin err++; $display("FAIL simul_nstart: got %0d want 3", bytes_q.size()); end
        vec++; if ({bytes_q[0], bytes_q[1], bytes_q[2]} !== 24'h471156) begin
            err++; $display("FAIL simul_pkt: got %h%h%h want 471156", bytes_q[0], bytes_q[1], bytes_q[2]); end
        vec++; if (dropped_count !== 8'd2) begin err++; $display("FAIL simul_dropped: got %0d want 2", dropped_count); end
    endtask

    task automatic test_fifo_full();
        int idle; bit to;
        logic [4:0] pos_tab [6];
        logic [4:0] exp_pos [5];
        logic [23:0] got, want;
        pos_tab = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000};
        exp_pos = '{5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
        do_reset(); reset = 1'b1; busy_force = 1'b1; step();
        // The first event is popped into the framer and parks in SEND behind busy
        mole_pos = 5'b10000; mole_event = 1'b1;
        step();
        mole_event = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 6; i++) begin
            mole_pos = pos_tab[i]; mole_event = 1'b1;
            step();
        end
        mole_event = 1'b0;
        vec++; if (fifo_count !== 3'd4) begin err++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        vec++; if (dropped_count !== 8'd2) begin err++; $display("FAIL full_dropped: got %0d want 2", dropped_count); end
        vec++; if (bytes_q.size() != 0) begin err++; $display("FAIL full_no_start: got %0d want 0", bytes_q.size()); end
        busy_force = 1'b0;
        wait_idle(800, idle, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL full_timeout: got %b want 0", to); end
        vec++; if (bytes_q.size() != 15) begin err++; $display("FAIL full_nstart: got %0d want 15", bytes_q.size()); end
        for (int p = 0; p < 5; p++) begin
            got  = {bytes_q[3*p], bytes_q[3*p+1], bytes_q[3*p+2]};
            want = {8'h4D, 3'b000, exp_pos[p], 8'h4D ^ {3'b000, exp_pos[p]}};
            vec++; if (got !== want) begin err++; $display("FAIL full_pkt%0d: got %h want %h", p, got, want); end
        end
    endtask

    task automatic test_ack_timeout();
        int k, idle; bit to;
        do_reset(); reset = 1'b1; model_en = 1'b0; step();
        k = cyc;
        score = 6'd42; hit_event = 1'b1;
        step();
        hit_event = 1'b0;
        wait_idle(200, idle, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL tmo_timeout: got %b want 0", to); end
        vec++; if (bytes_q.size() != 3) begin err++; $display("FAIL tmo_nstart: got %0d want 3", bytes_q.size()); end
        vec++; if ({bytes_q[0], bytes_q[1], bytes_q[2]} !== 24'h482A62) begin
            err++; $display("FAIL tmo_pkt: got %h%h%h want 482a62", bytes_q[0], bytes_q[1], bytes_q[2]); end
        vec++; if (starts_q[0] != k + 2) begin err++; $display("FAIL tmo_lat: got %0d want %0d", starts_q[0], k + 2); end
        vec++; if (starts_q[1] - starts_q[0] != ACK_TIMEOUT + 1) begin
            err++; $display("FAIL tmo_gap1: got %0d want %0d", starts_q[1] - starts_q[0], ACK_TIMEOUT + 1); end
        vec++; if (starts_q[2] - starts_q[1] != ACK_TIMEOUT + 1) begin
            err++; $display("FAIL tmo_gap2: got %0d want %0d", starts_q[2] - starts_q[1], ACK_TIMEOUT + 1); end
        vec++; if (idle != k + 17) begin err++; $display("FAIL tmo_idle: got %0d want %0d", idle, k + 17); end
        model_en = 1'b1;
    endtask

    task automatic test_push_pop_same_cycle();
        int idle; bit to;
        do_reset(); reset = 1'b1; step();
        score = 6'd5; hit_event = 1'b1;
        step();
        hit_event = 1'b0; mole_pos = 5'b00010; mole_event = 1'b1;
        vec++; if (fifo_count !== 3'd1) begin err++; $display("FAIL pp_count_before: got %0d want 1", fifo_count); end
        step();
        mole_event = 1'b0;
        vec++; if (fifo_count !== 3'd1) begin err++; $display("FAIL pp_count_after: got %0d want 1", fifo_count); end
        wait_idle(300, idle, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL pp_timeout: got %b want 0", to); end
        vec++; if (bytes_q.size() != 6) begin err++; $display("FAIL pp_nstart: got %0d want 6", bytes_q.size()); end
        vec++; if ({bytes_q[0], bytes_q[1], bytes_q[2]} !== 24'h48054D) begin
            err++; $display("FAIL pp_pkt0: got %h%h%h want 48054d", bytes_q[0], bytes_q[1], bytes_q[2]); end
        vec++; if ({bytes_q[3], bytes_q[4], bytes_q[5]} !== 24'h4D024F) begin
            err++; $display("FAIL pp_pkt1: got %h%h%h want 4d024f", bytes_q[3], bytes_q[4], bytes_q[5]); end
    endtask

    task automatic test_reset_mid_packet();
        int idle, n; bit to;
        do_reset(); reset = 1'b1; step();
        mole_pos = 5'b00001; mole_event = 1'b1;
        step();
        mole_event = 1'b0; score = 6'd3; hit_event = 1'b1;
        step();
        hit_event = 1'b0; score = 6'd9; over_event = 1'b1;
        step();
        over_event = 1'b0;
        vec++; if (fifo_count !== 3'd2) begin err++; $display("FAIL mid_queued: got %0d want 2", fifo_count); end
        n = 0;
        while (bytes_q.size() < 2 && n < 100) begin step(); n++; end
        vec++; if (bytes_q.size() != 2) begin err++; $display("FAIL mid_reach_b1: got %0d want 2", bytes_q.size()); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        vec++; if (tx_start !== 1'b0) begin err++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
        vec++; if (tx_data !== 8'h00) begin err++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
        vec++; if (framer_busy !== 1'b0) begin err++; $display("FAIL mid_busy: got %b want 0", framer_busy); end
        vec++; if (fifo_count !== 3'd0) begin err++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        vec++; if (dropped_count !== 8'd0) begin err++; $display("FAIL mid_dropped: got %0d want 0", dropped_count); end
        repeat (40) step();
        vec++; if (bytes_q.size() != 2) begin err++; $display("FAIL mid_no_restart: got %0d want 2", bytes_q.size()); end
        vec++; if ({bytes_q[0], bytes_q[1]} !== 16'h4D01) begin
            err++; $display("FAIL mid_first_bytes: got %h%h want 4d01", bytes_q[0], bytes_q[1]); end
        mole_pos = 5'b01000; mole_event = 1'b1;
        step();
        mole_event = 1'b0;
        wait_idle(300, idle, to);
        vec++; if (to !== 1'b0) begin err++; $display("FAIL mid_timeout: got %b want 0", to); end
        vec++; if (bytes_q.size() != 5) begin err++; $display("FAIL mid_nstart: got %0d want 5", bytes_q.size()); end
        vec++; if ({bytes_q[2], bytes_q[3], bytes_q[4]} !== 24'h4D0845) begin
            err++; $display("FAIL mid_new_pkt: got %h%h%h want 4d0845", bytes_q[2], bytes_q[3], bytes_q[4]); end
    endtask

    initial begin
        test_reset();
        test_single_mole();
        test_simultaneous();
        test_fifo_full();
        test_ack_timeout();
        test_push_pop_same_cycle();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
